// File: rtl/regfile_scoreboard.sv
// Integer register file with in-order issue scoreboard: NRD combinational read
// ports, one write-back per cycle, busy-bit tracking and RAW/WAW issue gating.

module regfile_rd_lane #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic [NREG-1:0][XLEN-1:0] regs,
  input  logic [NREG-1:0]           busy,
  input  logic [AW-1:0]             rd_addr,
  input  logic [AW-1:0]             rs,
  input  logic                      rs_en,
  input  logic                      wb_valid,
  input  logic [AW-1:0]             wb_addr,
  input  logic [XLEN-1:0]           wb_data,
  output logic [XLEN-1:0]           rd_data,
  output logic                      raw
);
  logic fwd_rd, fwd_rs;

  assign fwd_rd = (BYPASS != 0) && wb_valid && (wb_addr == rd_addr);
  assign fwd_rs = (BYPASS != 0) && wb_valid && (wb_addr == rs);

  always_comb begin
    rd_data = regs[rd_addr];
    if (rd_addr == '0) rd_data = '0;
    else if (fwd_rd)   rd_data = wb_data;
  end

  assign raw = rs_en && (rs != '0) && busy[rs] && !fwd_rs;
endmodule

module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG),
  localparam int CW    = AW + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  input  logic                iss_valid_i,
  input  logic [AW-1:0]       iss_rd_i,
  input  logic                iss_we_i,
  input  logic [NRD*AW-1:0]   iss_rs_i,
  input  logic [NRD-1:0]      iss_rs_en_i,
  output logic                iss_ready_o,
  input  logic                wb_valid_i,
  input  logic [AW-1:0]       wb_addr_i,
  input  logic [XLEN-1:0]     wb_data_i,
  input  logic                flush_i,
  output logic [CW-1:0]       busy_cnt_o
);
  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           busy;
  logic [NRD-1:0]            raw;
  logic                      waw, fire, set_hit, clr_hit, inc, dec;

  for (genvar k = 0; k < NRD; k++) begin : g_lane
    regfile_rd_lane #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(BYPASS)) u_lane (
      .regs     (regs),
      .busy     (busy),
      .rd_addr  (rd_addr_i[k*AW +: AW]),
      .rs       (iss_rs_i[k*AW +: AW]),
      .rs_en    (iss_rs_en_i[k]),
      .wb_valid (wb_valid_i),
      .wb_addr  (wb_addr_i),
      .wb_data  (wb_data_i),
      .rd_data  (rd_data_o[k*XLEN +: XLEN]),
      .raw      (raw[k])
    );
  end

  // A same-cycle write-back to the destination releases WAW regardless of BYPASS.
  assign waw = iss_we_i && (iss_rd_i != '0) && busy[iss_rd_i] &&
               !(wb_valid_i && (wb_addr_i == iss_rd_i));
  assign iss_ready_o = !(|raw) && !waw && !reset && !flush_i;

  assign fire    = iss_valid_i && iss_ready_o;
  assign set_hit = fire && iss_we_i && (iss_rd_i != '0);
  assign clr_hit = wb_valid_i && (wb_addr_i != '0) && busy[wb_addr_i];
  // Set and clear of the same register cancel in the count: busy stays 1.
  assign inc     = set_hit && !busy[iss_rd_i];
  assign dec     = clr_hit && !(set_hit && (iss_rd_i == wb_addr_i));

  always_ff @(posedge clk) begin
    if (reset) begin
      regs       <= '0;
      busy       <= '0;
      busy_cnt_o <= '0;
    end else begin
      if (wb_valid_i && (wb_addr_i != '0)) regs[wb_addr_i] <= wb_data_i;
      if (flush_i) begin
        busy       <= '0;
        busy_cnt_o <= '0;
      end else begin
        if (clr_hit) busy[wb_addr_i] <= 1'b0;
        if (set_hit) busy[iss_rd_i]  <= 1'b1;
        busy_cnt_o <= busy_cnt_o + {{(CW-1){1'b0}}, inc} - {{(CW-1){1'b0}}, dec};
      end
    end
  end
endmodule
